// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes plus data-memory strobes for the two-port data-memory arbiter
interface dmem_arbiter_if;
   logic        req0_i;
   logic        req1_i;
   logic        we0_i;
   logic        we1_i;
   logic [31:0] addr0_i;
   logic [31:0] addr1_i;
   logic [31:0] wdata0_i;
   logic [31:0] wdata1_i;
   logic        ack0_o;
   logic        ack1_o;
   logic        err0_o;
   logic        err1_o;
   logic [31:0] rdata0_o;
   logic [31:0] rdata1_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_data_i;
   modport slave (
      input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_data_i,
      output ack0_o, ack1_o, err0_o, err1_o, rdata0_o, rdata1_o,
             mem_addr_o, mem_data_o, mem_read_o, mem_write_o
   );
   modport master (
      output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_data_i,
      input  ack0_o, ack1_o, err0_o, err1_o, rdata0_o, rdata1_o,
             mem_addr_o, mem_data_o, mem_read_o, mem_write_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port word access sequencer for the single-port data memory; DMEM_ARB_RR_EN selects round-robin instead of fixed port-0 priority
module dmem_arbiter #(
   parameter int unsigned ADDR_LIMIT = 128
) (
   input logic           clk_i,
   input logic           rst_i,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
   state_t      state;
   state_t      state_n;
   logic        owner;
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata0_q;
   logic [31:0] rdata1_q;
   logic        any_req;
   logic        grant;
   logic        sel;
   logic        sel_we;
   logic        sel_err;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [32:0] end_addr;
   logic        mem_read;
   logic        mem_write;
   logic        ack0;
   logic        ack1;
   assign any_req = bus.req0_i | bus.req1_i;
   assign grant   = (state == IDLE) & any_req;
`ifdef DMEM_ARB_RR_EN
   logic rr_q;
   // Pointer names the favoured port: the one not granted most recently, error grants included
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)
         rr_q <= 1'b0;
      else if (grant)
         rr_q <= ~sel;
   assign sel = (bus.req0_i & bus.req1_i) ? rr_q : bus.req1_i;
`else
   assign sel = ~bus.req0_i;
`endif
   assign sel_we    = sel ? bus.we1_i    : bus.we0_i;
   assign sel_addr  = sel ? bus.addr1_i  : bus.addr0_i;
   assign sel_wdata = sel ? bus.wdata1_i : bus.wdata0_i;
   // 33-bit sum so that addresses wrapping past 2^32 are also rejected
   assign end_addr  = {1'b0, sel_addr} + 33'd3;
   assign sel_err   = (sel_addr[1:0] != 2'b00) || (end_addr >= 33'(ADDR_LIMIT));
   // State register; reset aborts any access in flight
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)
         state <= IDLE;
      else
         state <= state_n;
   // Next state and strobes, all decoded from state so reset drops them at once
   always_comb begin
      state_n   = (state == IDLE) ? (any_req ? SERVE : IDLE) : ((state == SERVE) ? DONE : IDLE);
      mem_read  = (state == SERVE) & ~we_q & ~err_q;
      mem_write = (state == SERVE) & we_q & ~err_q;
      ack0      = (state == DONE) & ~owner;
      ack1      = (state == DONE) & owner;
   end
   // Latch the winning request; the address/data registers double as the held memory bus
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         owner   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         owner   <= sel;
         we_q    <= sel_we;
         err_q   <= sel_err;
         addr_q  <= sel_addr;
         wdata_q <= sel_wdata;
      end
   // Capture read data at the end of SERVE; rejected accesses clear the owner's rdata
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if ((state == SERVE) && (err_q || !we_q)) begin
         if (owner)
            rdata1_q <= err_q ? 32'h0 : bus.mem_data_i;
         else
            rdata0_q <= err_q ? 32'h0 : bus.mem_data_i;
      end
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_data_o  = wdata_q;
   assign bus.mem_read_o  = mem_read;
   assign bus.mem_write_o = mem_write;
   assign bus.ack0_o      = ack0;
   assign bus.ack1_o      = ack1;
   assign bus.err0_o      = ack0 & err_q;
   assign bus.err1_o      = ack1 & err_q;
   assign bus.rdata0_o    = rdata0_q;
   assign bus.rdata1_o    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a word memory, a transaction-timeline model and a per-cycle compare
module tb_dmem_arbiter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   dmem_arbiter_if bus();
   dmem_arbiter #(.ADDR_LIMIT(128)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
   always #5 clk_i = ~clk_i;
   int vectors = 0;
   int miscompares = 0;
   int wr_cycles = 0;
   int rd_cycles = 0;
   logic [31:0] tbmem [32];
   logic [31:0] mmem [32];
   logic [31:0] rd_m [2];
   int ecount = 0;
   int g_e = 0;
   bit busy = 1'b0;
   bit rr = 1'b0;
   bit m_own, m_we, m_err;
   logic [31:0] m_addr, m_wdata;
   initial
      for (int i = 0; i < 32; i++) begin
         tbmem[i] = 32'h0;
         mmem[i]  = 32'h0;
      end
   // The physical memory the arbiter drives
   always @(posedge clk_i)
      if (bus.mem_write_o && bus.mem_addr_o < 32'd128)
         tbmem[bus.mem_addr_o[6:2]] <= bus.mem_data_o;
   assign bus.mem_data_i = (bus.mem_addr_o < 32'd128) ? tbmem[bus.mem_addr_o[6:2]] : 32'h0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Timeline model: an access granted at sampling edge g_e is served until g_e+1, acknowledged until g_e+2
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy    = 1'b0;
         rr      = 1'b0;
         rd_m[0] = 32'h0;
         rd_m[1] = 32'h0;
      end else begin
         ecount++;
         if (busy && ecount == g_e + 1) begin
            if (m_err)
               rd_m[m_own] = 32'h0;
            else if (m_we)
               mmem[m_addr[6:2]] = m_wdata;
            else
               rd_m[m_own] = mmem[m_addr[6:2]];
         end
         if (busy && ecount == g_e + 2)
            busy = 1'b0;
         else if (!busy && (bus.req0_i || bus.req1_i)) begin
`ifdef DMEM_ARB_RR_EN
            m_own = (bus.req0_i && bus.req1_i) ? rr : !bus.req0_i;
            rr    = !m_own;
`else
            m_own = !bus.req0_i;
`endif
            m_we    = m_own ? bus.we1_i : bus.we0_i;
            m_addr  = m_own ? bus.addr1_i : bus.addr0_i;
            m_wdata = m_own ? bus.wdata1_i : bus.wdata0_i;
            m_err   = (m_addr % 4 != 0) || (64'(m_addr) + 64'd3 >= 64'd128);
            g_e     = ecount;
            busy    = 1'b1;
         end
      end
   end
   // Per-cycle compare against the model, plus strobe counters
   always @(negedge clk_i) begin
      bit serve, done;
      serve = busy && ecount == g_e;
      done  = busy && ecount == g_e + 1;
      if (bus.mem_write_o) wr_cycles++;
      if (bus.mem_read_o) rd_cycles++;
      chk("ack0", 32'(bus.ack0_o), 32'(done && !m_own));
      chk("ack1", 32'(bus.ack1_o), 32'(done && m_own));
      if (done)
         chk("err", 32'(m_own ? bus.err1_o : bus.err0_o), 32'(m_err));
      chk("rdata0", bus.rdata0_o, rd_m[0]);
      chk("rdata1", bus.rdata1_o, rd_m[1]);
      chk("mem_write", 32'(bus.mem_write_o), 32'(serve && m_we && !m_err));
      chk("mem_read", 32'(bus.mem_read_o), 32'(serve && !m_we && !m_err));
      if (serve) begin
         chk("mem_addr", bus.mem_addr_o, m_addr);
         chk("mem_data", bus.mem_data_o, m_wdata);
      end
   end
   task automatic req_set(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         bus.req0_i = 1'b1; bus.we0_i = we; bus.addr0_i = a; bus.wdata0_i = d;
      end else begin
         bus.req1_i = 1'b1; bus.we1_i = we; bus.addr1_i = a; bus.wdata1_i = d;
      end
   endtask
   // One access from port p; returns negedges from request to ack and the err seen with ack
   task automatic access(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                         output int n, output bit e);
      n = 0;
      e = 1'b0;
      req_set(p, we, a, d);
      do begin
         @(negedge clk_i);
         n++;
      end while (!(p == 0 ? bus.ack0_o : bus.ack1_o) && n < 30);
      if (!(p == 0 ? bus.ack0_o : bus.ack1_o)) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout port %0d: no ack after %0d cycles", p, n);
      end
      e = (p == 0) ? bus.err0_o : bus.err1_o;
      if (p == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
      @(negedge clk_i);
   endtask
   // Both ports request at the same edge and drop on their own acks
   task automatic both(input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                       output int t0, output int t1);
      int n = 0;
      t0 = 0;
      t1 = 0;
      req_set(0, w0, a0, d0);
      req_set(1, w1, a1, d1);
      while ((t0 == 0 || t1 == 0) && n < 30) begin
         @(negedge clk_i);
         n++;
         if (bus.ack0_o) begin t0 = n; bus.req0_i = 1'b0; end
         if (bus.ack1_o) begin t1 = n; bus.req1_i = 1'b0; end
      end
      if (t0 == 0 || t1 == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL both_timeout: t0=%0d t1=%0d", t0, t1);
      end
      @(negedge clk_i);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n, t0, t1, wr0, rd0, m;
      bit e;
      bus.req0_i = 1'b0; bus.req1_i = 1'b0; bus.we0_i = 1'b0; bus.we1_i = 1'b0;
      bus.addr0_i = '0; bus.addr1_i = '0; bus.wdata0_i = '0; bus.wdata1_i = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_ack0", 32'(bus.ack0_o), 32'd0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk("rst_mem_write", 32'(bus.mem_write_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      wr0 = wr_cycles;
      access(0, 1'b1, 32'h10, 32'hDEADBEEF, n, e);
      chk("t1_wr_lat", 32'(n), 32'd2);
      chk("t1_wr_err", 32'(e), 32'd0);
      chk("t1_wr_pulses", 32'(wr_cycles - wr0), 32'd1);
      chk("t1_mem_word", tbmem[4], 32'hDEADBEEF);
      access(0, 1'b0, 32'h10, 32'h0, n, e);
      chk("t1_rd_lat", 32'(n), 32'd2);
      chk("t1_rd_err", 32'(e), 32'd0);
      chk("t1_rdata0", bus.rdata0_o, 32'hDEADBEEF);
      access(1, 1'b0, 32'h10, 32'h0, n, e);
      chk("t2_rdata1_ok", bus.rdata1_o, 32'hDEADBEEF);
      wr0 = wr_cycles;
      rd0 = rd_cycles;
      access(1, 1'b0, 32'h12, 32'h0, n, e);
      chk("t2_mis_err", 32'(e), 32'd1);
      chk("t2_mis_rdata1", bus.rdata1_o, 32'h0);
      access(1, 1'b0, 32'h7E, 32'h0, n, e);
      chk("t2_lim_err", 32'(e), 32'd1);
      access(1, 1'b0, 32'hFFFFFFFC, 32'h0, n, e);
      chk("t2_ovf_err", 32'(e), 32'd1);
      chk("t2_no_strobes", 32'((wr_cycles - wr0) + (rd_cycles - rd0)), 32'd0);
      chk("t2_mem_kept", tbmem[4], 32'hDEADBEEF);
      access(1, 1'b0, 32'h7C, 32'h0, n, e);
      chk("t2_edge_err", 32'(e), 32'd0);
      both(1'b1, 32'h0, 32'h11111111, 1'b1, 32'h4, 32'h22222222, t0, t1);
      chk("t3a_t0", 32'(t0), 32'd2);
      chk("t3a_t1", 32'(t1), 32'd5);
      chk("t3a_mem0", tbmem[0], 32'h11111111);
      chk("t3a_mem1", tbmem[1], 32'h22222222);
      access(0, 1'b0, 32'h8, 32'h0, n, e);
      both(1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0, t0, t1);
`ifdef DMEM_ARB_RR_EN
      chk("t3b_t1", 32'(t1), 32'd2);
      chk("t3b_t0", 32'(t0), 32'd5);
`else
      chk("t3b_t0", 32'(t0), 32'd2);
      chk("t3b_t1", 32'(t1), 32'd5);
`endif
      chk("t3b_rdata0", bus.rdata0_o, 32'h22222222);
      chk("t3b_rdata1", bus.rdata1_o, 32'h11111111);
      req_set(0, 1'b1, 32'h20, 32'hCAFEF00D);
      @(posedge clk_i);
      #1;
      chk("t4_serve_write", 32'(bus.mem_write_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("t4_write_drop", 32'(bus.mem_write_o), 32'd0);
      chk("t4_ack0", 32'(bus.ack0_o), 32'd0);
      chk("t4_mem_addr", bus.mem_addr_o, 32'h0);
      chk("t4_mem_data", bus.mem_data_o, 32'h0);
      chk("t4_rdata0", bus.rdata0_o, 32'h0);
      bus.req0_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("t4_mem_word", tbmem[8], 32'h0);
      access(0, 1'b1, 32'h0, 32'h11111111, n, e);
      req_set(0, 1'b0, 32'h0, 32'h0);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!bus.ack0_o && n < 30);
      chk("t5_first_lat", 32'(n), 32'd2);
      m = 0;
      do begin
         @(negedge clk_i);
         m++;
         if (m == 2) bus.req0_i = 1'b0;
      end while (!bus.ack0_o && m < 30);
      chk("t5_second_gap", 32'(m), 32'd3);
      chk("t5_rdata0", bus.rdata0_o, 32'h11111111);
      bus.req0_i = 1'b0;
      repeat (4) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port byte-addressed data memory. Two requesters (port 0: CPU load/store stage, port 1: testbench/debug loader) issue 32-bit word read/write requests. The block grants one at a time, drives the memory's address, data, read and write strobes for exactly one cycle, captures read data, and returns a one-cycle acknowledge. It also rejects misaligned or out-of-range accesses.

## Interface
- ADDR_LIMIT, 128: byte size of the populated memory. Accesses with addr + 3 ≥ ADDR_LIMIT are errors.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req0_i / req1_i  input  1  request from port n; held high until acknowledged.
- we0_i / we1_i  input  1  1 = write, 0 = read; qualified by reqn_i.
- addr0_i / addr1_i  input  32  byte address.
- wdata0_i / wdata1_i  input  32  write data.
- ack0_o / ack1_o  output  1  one-cycle completion pulse.
- err0_o / err1_o  output  1  valid with ackn_o; 1 = access rejected.
- rdata0_o / rdata1_o  output  32  read data; valid with ackn_o and held until the next ack on that port.
- mem_addr_o  output  32  to memory addr_i.
- mem_data_o  output  32  to memory data_i.
- mem_read_o  output  1  to memory MemRead_i.
- mem_write_o  output  1  to memory MemWrite_i.
- mem_data_i  input  32  from memory data_o (combinational read).

## Operation
- FSM with three states: IDLE, SERVE, DONE.
- IDLE:
  - If any reqn_i is high at a clock edge, select an owner.
  - Latch the owner's we, addr and wdata, and evaluate the error condition: addr[1:0] ≠ 0, or addr + 3 ≥ ADDR_LIMIT (32-bit compare; overflow counts as an error).
  - Go to SERVE.
- SERVE (exactly one cycle):
  - mem_addr_o and mem_data_o carry the latched values.
  - mem_write_o = we & ~err; mem_read_o = ~we & ~err.
  - The memory performs the write on the edge that ends SERVE.
  - On that same edge, mem_data_i is captured into the owner's rdata register for reads. On an error, rdata is set to 0.
  - Go to DONE.
- DONE: drive the owner's ackn_o = 1 and errn_o = err. Go to IDLE unconditionally.
- Outside SERVE:
  - mem_read_o = mem_write_o = 0.
  - mem_addr_o and mem_data_o hold their last values. The memory output latches while MemRead is low, so this is harmless.
- Requester rule: deassert reqn_i on the edge where ackn_o is seen high. A request still high in the IDLE cycle after DONE is a new access.
- Writes do not modify rdata.
- The non-owner's request waits with no side effects.

## Timing
- Reset values: state IDLE; all ack/err 0; rdata 0; mem_addr_o 0; mem_data_o 0; mem_read_o 0; mem_write_o 0; round-robin pointer favours port 0.
- Latency: request sampled at edge k → SERVE in cycle k..k+1 → ack high in cycle k+1..k+2.
- Throughput: one access per 3 cycles, regardless of port.
- Simultaneous requests: resolved at the IDLE sampling edge only (see Configuration).
- A request rising during SERVE or DONE is not sampled until the next IDLE.
- Reset mid-SERVE: mem_write_o falls immediately (asynchronously), so no memory write occurs; no ack is issued.
- Reset mid-DONE: ack clears immediately.
- The pending access is lost; the requester must reissue it.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin arbitration. On simultaneous requests, the port not granted most recently wins.
  - A 1-bit pointer updates at every grant, including error grants.
- Undefined: fixed priority; port 0 always wins simultaneous requests, and the pointer logic is absent.
- Single-requester behaviour is identical in both builds.

## Test plan
- Port 0 write, addr 0x10, data 0xDEADBEEF; then read 0x10 → mem_write_o high for exactly one cycle; read ack0_o 2 cycles after sampling with rdata0_o = 0xDEADBEEF; err0_o = 0.
- Port 1 read, addr 0x12 (misaligned) and addr 0x7E (≥ ADDR_LIMIT−3) → err1_o = 1 with ack, rdata1_o = 0, mem_read_o/mem_write_o never asserted, memory unchanged.
- Both ports request at the same edge, held continuously (port 0 writes 0x11111111 @0x0, port 1 writes 0x22222222 @0x4) → with DMEM_ARB_RR_EN: grants 0,1 alternate; without: port 0 is served first, then port 1. Each ack arrives 3 cycles apart.
- Assert rst_i during SERVE of a write of 0xCAFEF00D @0x20 → mem_write_o drops in the same cycle, word at 0x20 stays 0, no ack, state IDLE, all outputs at reset values.
- Port 0 keeps req0_i high one cycle past ack → a second identical access is performed and acknowledged 3 cycles after the first.
